fpu_issue_queue: RTL and testbench
==================================

# fpu_issue_queue

Operand issue stage sitting directly upstream of the combinational bfloat16 `fpu` (add/sub/mul/div). Accepts `{op, in1, in2, tag}` requests over a valid/ready handshake and buffers them in a small FIFO. It presents the head entry to the `fpu` ports and captures `out_o`/`overflow_o` into a registered response slot with its own valid/ready handshake. This decouples a producer and consumer that stall independently from the purely combinational datapath.

## Interface
Parameters:
- `DEPTH`, 4, request FIFO entries; power of two, ≥2.
- `TAG_W`, 4, width of the opaque request tag returned with the result.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  request FIFO can accept.
- `req_op_i`  in  4  one-hot op: 0001 add, 0010 sub, 0100 mul, 1000 div.
- `req_in1_i`, `req_in2_i`  in  16 each  bfloat16 operands.
- `req_tag_i`  in  TAG_W  request tag.
- `fpu_op_o`  out  4  to `fpu.op_i`.
- `fpu_in1_o`, `fpu_in2_o`  out  16 each  to `fpu.in1_i` / `fpu.in2_i`.
- `fpu_out_i`  in  16  from `fpu.out_o`.
- `fpu_overflow_i`  in  1  from `fpu.overflow_o`.
- `rsp_valid_o`  out  1  response slot full.
- `rsp_ready_i`  in  1  consumer takes response.
- `rsp_out_o`  out  16  result.
- `rsp_overflow_o`  out  1  captured overflow flag.
- `rsp_badop_o`  out  1  request op was not one-hot.
- `rsp_tag_o`  out  TAG_W  tag of the response.
- `ovf_count_o`  out  16  saturating count of overflowed results.

## Operation
- Storage:
  - FIFO of DEPTH entries `{op, in1, in2, tag}` with wrap-around read/write pointers.
  - Occupancy counter of width log2(DEPTH)+1.
- Push: `req_valid_i && req_ready_o`. `req_ready_o = (count != DEPTH)`, derived from registered count only. A full FIFO never accepts in the same cycle as a pop.
- FPU drive:
  - Head entry non-empty and op one-hot: `fpu_*` outputs = head fields.
  - Otherwise (empty, or head op not one-hot): `fpu_op_o = 4'b0000`, `fpu_in1_o = fpu_in2_o = 16'h0000`.
- Capture/pop condition: FIFO non-empty && (`!rsp_valid_o` || `rsp_ready_i`). On that edge:
  - Head op one-hot:
    - `rsp_out_o` ← `fpu_out_i`.
    - `rsp_overflow_o` ← `fpu_overflow_i`.
    - `rsp_badop_o` ← 0.
  - Head op not one-hot: `rsp_out_o` ← 16'h7FC0, `rsp_overflow_o` ← 0, `rsp_badop_o` ← 1.
  - `rsp_tag_o` ← head tag.
  - `rsp_valid_o` ← 1.
  - Head popped.
- Drain without capture: `rsp_valid_o && rsp_ready_i` with empty FIFO → `rsp_valid_o` ← 0; data fields hold.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Results retire strictly in request order.

## Timing
- All outputs on reset:
  - `req_ready_o` = 1.
  - `rsp_valid_o`, `rsp_overflow_o`, `rsp_badop_o` = 0.
  - `rsp_out_o` = 0, `rsp_tag_o` = 0.
  - `fpu_op_o` = 0, `fpu_in1_o` = `fpu_in2_o` = 0.
  - `ovf_count_o` = 0.
  - Pointers and count = 0.
- Latency: a request accepted at edge N into an empty FIFO with a free/draining slot drives `fpu_*` after N and is visible on `rsp_*` after edge N+1. Throughput is one result per cycle while `rsp_ready_i` = 1.
- `fpu` path is combinational within one cycle: `fpu_*` outputs → `fpu_out_i` → response register.
- Max buffering: DEPTH in FIFO + 1 in response slot.
- Reset asserted mid-operation discards all queued and held entries immediately (async). The first accept is possible at the first rising edge after deassertion.
- `rsp_*` data must stay stable while `rsp_valid_o && !rsp_ready_i`.

## Configuration
- `FPU_IQ_OVF_CNT_EN` defined:
  - `ovf_count_o` increments by 1 on each capture with `fpu_overflow_i` = 1 and op one-hot.
  - It saturates at 16'hFFFF and is cleared only by reset.
- Undefined: counter logic absent; `ovf_count_o` tied to 16'h0000.

## Test plan
- Single add: op 0001, in1 3F80, in2 4000, tag 1 → `rsp_out_o` 4040, overflow 0, badop 0, tag 1, one cycle after accept.
- Back-to-back stream of 3 muls (4000×4040, 3F80×3F80, 4040×4040) with `rsp_ready_i` = 1 → results 40C0, 3F80, 4110 on consecutive cycles, in order.
- Backpressure: `rsp_ready_i` = 0, DEPTH=4, continuous valid → exactly 5 accepted, then `req_ready_o` = 0. Raise `rsp_ready_i` → 5 in-order responses; `req_ready_o` reasserts after the first pop.
- Overflow: mul 7F7F×4000 → `rsp_overflow_o` 1. With `FPU_IQ_OVF_CNT_EN`, `ovf_count_o` = 1; without it, `ovf_count_o` = 0.
- Bad op: op 0011 → `fpu_op_o` 0000 while at head; response 7FC0, badop 1, overflow 0, counter unchanged.
- Reset mid-stream: 3 entries queued, slot full, `rst_n` low for 1 cycle → all outputs at reset values immediately. No stale response appears after release.

Source files
------------

// File: rtl/fpu_issue_queue.sv
// rtl/fpu_issue_queue.sv - request FIFO and registered response slot around the combinational bfloat16 fpu
// Optional: define FPU_IQ_OVF_CNT_EN to build the saturating overflow counter behind ovf_count_o.
module fpu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [3:0]       req_op_i,
    input  logic [15:0]      req_in1_i,
    input  logic [15:0]      req_in2_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic [3:0]       fpu_op_o,
    output logic [15:0]      fpu_in1_o,
    output logic [15:0]      fpu_in2_o,
    input  logic [15:0]      fpu_out_i,
    input  logic             fpu_overflow_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [15:0]      rsp_out_o,
    output logic             rsp_overflow_o,
    output logic             rsp_badop_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic [15:0]      ovf_count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] W_FULL = (AW + 1)'(DEPTH);

    logic [3:0]       r_op_mem  [DEPTH];
    logic [15:0]      r_in1_mem [DEPTH];
    logic [15:0]      r_in2_mem [DEPTH];
    logic [TAG_W-1:0] r_tag_mem [DEPTH];

    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    logic             r_rsp_valid;
    logic [15:0]      r_rsp_out;
    logic             r_rsp_overflow;
    logic             r_rsp_badop;
    logic [TAG_W-1:0] r_rsp_tag;

    logic             w_push;
    logic             w_pop;
    logic             w_nonempty;
    logic [3:0]       w_head_op;
    logic             w_head_onehot;
    logic             w_head_ok;

    // Ready comes only from the registered count, so a full FIFO waits a cycle after a pop.
    assign req_ready_o   = (r_count != W_FULL);
    assign w_push        = req_valid_i && req_ready_o;
    assign w_nonempty    = (r_count != '0);
    assign w_pop         = w_nonempty && (!r_rsp_valid || rsp_ready_i);
    assign w_head_op     = r_op_mem[r_rptr];
    assign w_head_onehot = (w_head_op != 4'b0000) && ((w_head_op & (w_head_op - 4'd1)) == 4'b0000);
    assign w_head_ok     = w_nonempty && w_head_onehot;

    assign fpu_op_o  = w_head_ok ? w_head_op          : 4'b0000;
    assign fpu_in1_o = w_head_ok ? r_in1_mem[r_rptr]  : 16'h0000;
    assign fpu_in2_o = w_head_ok ? r_in2_mem[r_rptr]  : 16'h0000;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op_mem[r_wptr]  <= req_op_i;
            r_in1_mem[r_wptr] <= req_in1_i;
            r_in2_mem[r_wptr] <= req_in2_i;
            r_tag_mem[r_wptr] <= req_tag_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A malformed op never reaches the fpu; it retires as a quiet NaN flagged badop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_out      <= 16'h0000;
            r_rsp_overflow <= 1'b0;
            r_rsp_badop    <= 1'b0;
            r_rsp_tag      <= '0;
        end else if (w_pop) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_tag      <= r_tag_mem[r_rptr];
            if (w_head_onehot) begin
                r_rsp_out      <= fpu_out_i;
                r_rsp_overflow <= fpu_overflow_i;
                r_rsp_badop    <= 1'b0;
            end else begin
                r_rsp_out      <= 16'h7FC0;
                r_rsp_overflow <= 1'b0;
                r_rsp_badop    <= 1'b1;
            end
        end else if (r_rsp_valid && rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid_o    = r_rsp_valid;
    assign rsp_out_o      = r_rsp_out;
    assign rsp_overflow_o = r_rsp_overflow;
    assign rsp_badop_o    = r_rsp_badop;
    assign rsp_tag_o      = r_rsp_tag;

`ifdef FPU_IQ_OVF_CNT_EN
    logic [15:0] r_ovf_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_count <= 16'h0000;
        end else if (w_pop && w_head_onehot && fpu_overflow_i && (r_ovf_count != 16'hFFFF)) begin
            r_ovf_count <= r_ovf_count + 16'd1;
        end
    end

    assign ovf_count_o = r_ovf_count;
`else
    assign ovf_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_fpu_issue_queue.sv
// tb/tb_fpu_issue_queue.sv - table, directed and randomized checks of fpu_issue_queue against a queue model
module tb_fpu_issue_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [3:0]       req_op_i;
    logic [15:0]      req_in1_i;
    logic [15:0]      req_in2_i;
    logic [TAG_W-1:0] req_tag_i;
    logic [3:0]       fpu_op_o;
    logic [15:0]      fpu_in1_o;
    logic [15:0]      fpu_in2_o;
    logic [15:0]      fpu_out_i;
    logic             fpu_overflow_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [15:0]      rsp_out_o;
    logic             rsp_overflow_o;
    logic             rsp_badop_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic [15:0]      ovf_count_o;

    always #5 clk = ~clk;

    fpu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_in1_i(req_in1_i), .req_in2_i(req_in2_i), .req_tag_i(req_tag_i),
        .fpu_op_o(fpu_op_o), .fpu_in1_o(fpu_in1_o), .fpu_in2_o(fpu_in2_o),
        .fpu_out_i(fpu_out_i), .fpu_overflow_i(fpu_overflow_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_out_o(rsp_out_o), .rsp_overflow_o(rsp_overflow_o), .rsp_badop_o(rsp_badop_o),
        .rsp_tag_o(rsp_tag_o), .ovf_count_o(ovf_count_o)
    );

    // Stand-in for the fpu: exact results for the known operand pairs, a fixed scramble otherwise.
    function automatic logic [16:0] fake_fpu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        if (op == 4'b0001 && a == 16'h3F80 && b == 16'h4000) return {1'b0, 16'h4040};
        if (op == 4'b0100 && a == 16'h4000 && b == 16'h4040) return {1'b0, 16'h40C0};
        if (op == 4'b0100 && a == 16'h3F80 && b == 16'h3F80) return {1'b0, 16'h3F80};
        if (op == 4'b0100 && a == 16'h4040 && b == 16'h4040) return {1'b0, 16'h4110};
        if (op == 4'b0100 && a == 16'h7F7F && b == 16'h4000) return {1'b1, 16'h7F80};
        return {(a[15:12] == 4'hF), (a ^ {b[7:0], b[15:8]}) + {12'h000, op}};
    endfunction

    always_comb begin
        {fpu_overflow_i, fpu_out_i} = fake_fpu(fpu_op_o, fpu_in1_o, fpu_in2_o);
    end

    typedef struct {
        logic [3:0]  op;
        logic [15:0] in1;
        logic [15:0] in2;
        logic [3:0]  tag;
    } req_t;

    typedef struct {
        logic [15:0] out;
        logic        ovf;
        logic        bad;
        logic [3:0]  tag;
    } rsp_t;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] in1;
        logic [15:0] in2;
        logic [3:0]  tag;
        logic [15:0] exp_out;
        logic        exp_ovf;
        logic        exp_bad;
    } vec_t;

    req_t        mq[$];
    rsp_t        m_slot;
    logic        m_slot_valid = 1'b0;
    int unsigned m_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_acc = 0;
    vec_t        vecs[6];

    function automatic logic is_onehot(input logic [3:0] op);
        return $countones(op) == 1;
    endfunction

    function automatic rsp_t resolve(input req_t r);
        rsp_t        s;
        logic [16:0] f;
        f = fake_fpu(r.op, r.in1, r.in2);
        s.tag = r.tag;
        if (is_onehot(r.op)) begin
            s.out = f[15:0]; s.ovf = f[16]; s.bad = 1'b0;
        end else begin
            s.out = 16'h7FC0; s.ovf = 1'b0; s.bad = 1'b1;
        end
        return s;
    endfunction

    function automatic int unsigned exp_cnt(input int unsigned c);
`ifdef FPU_IQ_OVF_CNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_ovf", rsp_overflow_o, 0);
        chk("rst_rsp_bad", rsp_badop_o, 0);
        chk("rst_rsp_out", rsp_out_o, 0);
        chk("rst_rsp_tag", rsp_tag_o, 0);
        chk("rst_fpu_op", fpu_op_o, 0);
        chk("rst_fpu_in1", fpu_in1_o, 0);
        chk("rst_fpu_in2", fpu_in2_o, 0);
        chk("rst_ovf_count", ovf_count_o, 0);
    endtask

    // Called at a falling edge: check outputs against the model, drive one cycle, advance the model.
    task automatic step(input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] tg, input logic rr);
        req_t r;
        logic push, pop, retire;
        chk("req_ready", req_ready_o, (mq.size() != DEPTH));
        chk("rsp_valid", rsp_valid_o, m_slot_valid);
        if (m_slot_valid) begin
            chk("rsp_out", rsp_out_o, m_slot.out);
            chk("rsp_ovf", rsp_overflow_o, m_slot.ovf);
            chk("rsp_bad", rsp_badop_o, m_slot.bad);
            chk("rsp_tag", rsp_tag_o, m_slot.tag);
        end
        if (mq.size() > 0 && is_onehot(mq[0].op)) begin
            chk("fpu_op", fpu_op_o, mq[0].op);
            chk("fpu_in1", fpu_in1_o, mq[0].in1);
            chk("fpu_in2", fpu_in2_o, mq[0].in2);
        end else begin
            chk("fpu_op_idle", fpu_op_o, 0);
            chk("fpu_ins_idle", {fpu_in1_o, fpu_in2_o}, 0);
        end
        chk("ovf_count", ovf_count_o, exp_cnt(m_cnt));
        req_valid_i = v; req_op_i = op; req_in1_i = a; req_in2_i = b; req_tag_i = tg; rsp_ready_i = rr;
        if (v && req_ready_o) n_acc++;
        push   = v && (mq.size() != DEPTH);
        retire = m_slot_valid && rr;
        pop    = (mq.size() > 0) && (!m_slot_valid || rr);
        if (pop) begin
            r = mq.pop_front();
            m_slot = resolve(r);
            m_slot_valid = 1'b1;
            if (is_onehot(r.op) && m_slot.ovf && m_cnt != 32'hFFFF) m_cnt++;
        end else if (retire) begin
            m_slot_valid = 1'b0;
        end
        if (push) begin
            r.op = op; r.in1 = a; r.in2 = b; r.tag = tg;
            mq.push_back(r);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (mq.size() > 0 || m_slot_valid); i++) step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        vecs[0] = '{4'b0001, 16'h3F80, 16'h4000, 4'h1, 16'h4040, 1'b0, 1'b0};
        vecs[1] = '{4'b0100, 16'h4000, 16'h4040, 4'h2, 16'h40C0, 1'b0, 1'b0};
        vecs[2] = '{4'b0100, 16'h3F80, 16'h3F80, 4'h3, 16'h3F80, 1'b0, 1'b0};
        vecs[3] = '{4'b0100, 16'h4040, 16'h4040, 4'h4, 16'h4110, 1'b0, 1'b0};
        vecs[4] = '{4'b0100, 16'h7F7F, 16'h4000, 4'h5, 16'h7F80, 1'b1, 1'b0};
        vecs[5] = '{4'b0011, 16'h3F80, 16'h4000, 4'h6, 16'h7FC0, 1'b0, 1'b1};

        rst_n = 1'b0;
        req_valid_i = 0; req_op_i = 0; req_in1_i = 0; req_in2_i = 0; req_tag_i = 0; rsp_ready_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            step(1, vecs[i].op, vecs[i].in1, vecs[i].in2, vecs[i].tag, 1);
            chk("tbl_fpu_op", fpu_op_o, is_onehot(vecs[i].op) ? vecs[i].op : 4'b0000);
            step(0, 0, 0, 0, 0, 1);
            chk("tbl_valid", rsp_valid_o, 1);
            chk("tbl_out", rsp_out_o, vecs[i].exp_out);
            chk("tbl_ovf", rsp_overflow_o, vecs[i].exp_ovf);
            chk("tbl_bad", rsp_badop_o, vecs[i].exp_bad);
            chk("tbl_tag", rsp_tag_o, vecs[i].tag);
            drain();
        end
`ifdef FPU_IQ_OVF_CNT_EN
        chk("tbl_ovf_count", ovf_count_o, 1);
`else
        chk("tbl_ovf_count", ovf_count_o, 0);
`endif

        step(1, 4'b0100, 16'h4000, 16'h4040, 4'h7, 1);
        step(1, 4'b0100, 16'h3F80, 16'h3F80, 4'h8, 1);
        chk("b2b_r0", rsp_out_o, 16'h40C0);
        step(1, 4'b0100, 16'h4040, 16'h4040, 4'h9, 1);
        chk("b2b_r1", rsp_out_o, 16'h3F80);
        step(0, 0, 0, 0, 0, 1);
        chk("b2b_r2", rsp_out_o, 16'h4110);
        chk("b2b_tag2", rsp_tag_o, 4'h9);
        drain();

        n_acc = 0;
        for (int i = 0; i < 7; i++) step(1, 4'b0001, 16'(i * 16), 16'h1234, 4'(i), 0);
        chk("bp_accepted", n_acc, 5);
        chk("bp_not_ready", req_ready_o, 0);
        chk("bp_hold_tag", rsp_tag_o, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("bp_ready_again", req_ready_o, 1);
        chk("bp_next_tag", rsp_tag_o, 1);
        drain();

        for (int i = 0; i < 4; i++) step(1, 4'b0010, 16'h4000, 16'(i), 4'(8 + i), 0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        mq.delete();
        m_slot_valid = 1'b0;
        m_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
        step(1, 4'b0001, 16'h3F80, 16'h4000, 4'hA, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("post_rst_out", rsp_out_o, 16'h4040);
        chk("post_rst_tag", rsp_tag_o, 4'hA);
        drain();

        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), op, 16'($urandom), 16'($urandom), 4'($urandom),
                 ($urandom_range(0, 3) != 0));
        end
        drain();
        chk("end_idle_valid", rsp_valid_o, 0);
        chk("end_idle_ready", req_ready_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
